lsu_pipe: RTL and testbench
===========================

Name: lsu_pipe

Overview:
- Parametrised load/store unit that sits between the EXE stage and the data memory port.
- Replaces the single-outstanding mem_stage FSM with an issue register plus an in-order outstanding-request FIFO of configurable depth.
- Drives the memory's valid/yumi handshake and returns load data to writeback in request order.
- Asserts busy_o so the core can stall.

Parameters:
- ADDR_WIDTH_P, 32, data-memory address width
- DATA_WIDTH_P, 32, data width
- TAG_WIDTH_P, 5, destination-register tag width
- DEPTH_P, 2, max in-flight accesses including the issue register (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- req_valid_i  in  1  EXE presents a memory op
- req_is_store_i  in  1  1=store, 0=load
- req_byte_i  in  1  byte (not word) access
- req_addr_i  in  ADDR_WIDTH_P  effective address (ALU result)
- req_wdata_i  in  DATA_WIDTH_P  store data
- req_tag_i  in  TAG_WIDTH_P  load destination register
- req_ready_o  out  1  request accepted this cycle when high with req_valid_i
- mem_valid_o  out  1  request to memory
- mem_addr_o  out  ADDR_WIDTH_P  request address
- mem_wdata_o  out  DATA_WIDTH_P  write data
- mem_wen_o  out  1  store
- mem_byte_o  out  1  byte_not_word
- mem_accept_i  in  1  memory yumi: request taken
- mem_resp_valid_i  in  1  memory response valid
- mem_rdata_i  in  DATA_WIDTH_P  read data
- mem_yumi_o  out  1  response consumed
- wb_valid_o  out  1  load result available
- wb_tag_o  out  TAG_WIDTH_P  destination register
- wb_data_o  out  DATA_WIDTH_P  load data
- wb_ready_i  in  1  writeback may commit (low on RF structural hazard)
- busy_o  out  1  any access pending or outstanding
- proto_err_o  out  1  sticky protocol error
- align_err_o  out  1  see Optional Feature

Behaviour:
Reset:
- All state clears: pend_r=0, cnt_r=0, FIFO pointers=0, proto_err_o=0.
- Every output is 0 during and after reset; req_ready_o is 1 once reset deasserts.
- Reset mid-operation drops all pending and outstanding entries. Memory must be reset in the same cycle.

Issue:
- req_ready_o = (!pend_r || mem_accept_i) && (cnt_r + pend_r < DEPTH_P).
- On accept, the fields are captured into the issue register and pend_r=1.
- mem_valid_o = pend_r, so a request accepted in cycle N appears at memory in cycle N+1.
- Fields are held stable until mem_accept_i.

Outstanding FIFO:
- On mem_accept_i && pend_r, {is_store, byte, tag} is pushed and cnt_r increments.
- Circular pointers wrap at DEPTH_P; DEPTH_P need not be a power of 2.
- cnt_r width is $clog2(DEPTH_P+1).

Response:
- Responses are strictly in order; the head entry defines the meaning of each response.
- Load head: wb_valid_o = mem_resp_valid_i.
- Byte load: wb_data_o = {zeros, mem_rdata_i[7:0]}; word load: wb_data_o = mem_rdata_i. wb_tag_o = head tag.
- mem_yumi_o = mem_resp_valid_i && cnt_r!=0 && (head.is_store || wb_ready_i); the pop happens on that same condition.
- Store responses never raise wb_valid_o.
- mem_resp_valid_i with cnt_r==0: ignored, mem_yumi_o=0, proto_err_o set (sticky until reset).
- Simultaneous push and pop: cnt_r is unchanged and both pointers advance.
- A response may pop an entry pushed in an earlier cycle only; a same-cycle accept+response with cnt_r==0 counts as a protocol error.

busy_o = pend_r || cnt_r!=0.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined: a word request with req_addr_i[1:0]!=0 is accepted (req_ready_o rules apply) but not issued. align_err_o pulses 1 for one cycle, the cycle after acceptance, and no FIFO entry is created.
- Undefined: align_err_o tied to 0 and addresses are passed through unchecked.

Decomposition:
- Shared package definitions: lsu_entry_s {is_store, byte, tag} and lsu_req_s {is_store, byte, addr, wdata, tag}, sized from package constants.
- One sub-module: lsu_fifo (parametrised DEPTH_P/WIDTH, push/pop/count/head, simultaneous push-pop).

Test Plan:
- Single word load: addr 0x10, tag 3, memory accepts in cycle 1, responds 0xDEADBEEF in cycle 3 with wb_ready_i=1 -> wb_valid_o=1, wb_tag_o=3, wb_data_o=0xDEADBEEF, mem_yumi_o=1, busy_o=0 the next cycle.
- DEPTH_P=2, memory never responds: issue two loads -> second accepted, third sees req_ready_o=0 while cnt_r=1 and pend_r=1. After one response, req_ready_o=1 again.
- Byte load returning 0x123456A7 -> wb_data_o=0x000000A7. A store response raises mem_yumi_o=1 with wb_valid_o=0 even when wb_ready_i=0.
- Load response with wb_ready_i=0 for 3 cycles -> mem_yumi_o=0 and wb_valid_o held for those cycles; yumi asserts on the cycle wb_ready_i=1.
- Spurious mem_resp_valid_i when idle -> proto_err_o=1 and stays set; a reset pulse clears it. Reset during a pending request -> mem_valid_o=0 the following cycle.
- With LSU_ALIGN_CHECK_EN: word store at 0x6 -> align_err_o pulses once, mem_valid_o stays 0. Byte store at 0x6 is issued normally.

Source files
------------

// File: rtl/lsu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pipe_pkg
//   Shared definitions for the load/store unit slice.
//   - Default widths/depth used as parameter defaults by lsu_pipe and
//     lsu_pipe_if.
//   - lsu_req_s   : one request as held in the issue register.
//   - lsu_entry_s : one outstanding-FIFO entry (what a response will mean).
//   - lsu_load_data  : writeback formatting of read data (byte zero-extend).
//   - lsu_misaligned : word access with a non-zero low address pair, used only
//                      when LSU_ALIGN_CHECK_EN is defined.
// -----------------------------------------------------------------------------
package lsu_pipe_pkg;

  localparam int LSU_ADDR_W = 32;
  localparam int LSU_DATA_W = 32;
  localparam int LSU_TAG_W  = 5;
  localparam int LSU_DEPTH  = 2;

  typedef struct packed {
    logic                  is_store;
    logic                  byte_op;
    logic [LSU_TAG_W-1:0]  tag;
  } lsu_entry_s;

  typedef struct packed {
    logic                  is_store;
    logic                  byte_op;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] wdata;
    logic [LSU_TAG_W-1:0]  tag;
  } lsu_req_s;

  localparam int LSU_ENTRY_W = $bits(lsu_entry_s);

  // Byte loads return the addressed byte in bits [7:0], zero-extended.
  function automatic logic [LSU_DATA_W-1:0] lsu_load_data(
    input logic                  is_byte,
    input logic [LSU_DATA_W-1:0] rdata
  );
    if (is_byte) begin
      return {{(LSU_DATA_W-8){1'b0}}, rdata[7:0]};
    end
    return rdata;
  endfunction

  function automatic logic lsu_misaligned(
    input logic       is_byte,
    input logic [1:0] addr_lo
  );
    return !is_byte && (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_pipe_if.sv
// -----------------------------------------------------------------------------
// lsu_pipe_if
//   Data-memory port of the load/store unit.
//   Request channel : mem_valid_o/mem_accept_i with addr, wdata, wen, byte.
//   Response channel: mem_resp_valid_i/mem_yumi_o with rdata.
//   Signal suffixes are from the LSU's point of view.
//   modport master : used by lsu_pipe.
//   modport slave  : used by a memory model / memory controller.
//
//   Handshake: a request transfers on a rising clk edge where mem_valid_o and
//   mem_accept_i are both high; request fields are held stable while
//   mem_valid_o is high and mem_accept_i is low. A response transfers on an
//   edge where mem_resp_valid_i and mem_yumi_o are both high; the memory holds
//   mem_resp_valid_i and mem_rdata_i stable until then. Responses arrive in
//   request order.
// -----------------------------------------------------------------------------
interface lsu_pipe_if
  import lsu_pipe_pkg::*;
#(
  parameter int ADDR_WIDTH_P = LSU_ADDR_W,
  parameter int DATA_WIDTH_P = LSU_DATA_W
);

  logic                    mem_valid_o;
  logic [ADDR_WIDTH_P-1:0] mem_addr_o;
  logic [DATA_WIDTH_P-1:0] mem_wdata_o;
  logic                    mem_wen_o;
  logic                    mem_byte_o;
  logic                    mem_accept_i;
  logic                    mem_resp_valid_i;
  logic [DATA_WIDTH_P-1:0] mem_rdata_i;
  logic                    mem_yumi_o;

  modport master (
    output mem_valid_o, mem_addr_o, mem_wdata_o, mem_wen_o, mem_byte_o,
    output mem_yumi_o,
    input  mem_accept_i, mem_resp_valid_i, mem_rdata_i
  );

  modport slave (
    input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_wen_o, mem_byte_o,
    input  mem_yumi_o,
    output mem_accept_i, mem_resp_valid_i, mem_rdata_i
  );

endinterface

// File: rtl/lsu_fifo.sv
// -----------------------------------------------------------------------------
// lsu_fifo
//   Small circular FIFO holding the outstanding memory accesses in order.
//   Ports:
//     clk, reset    : clock, synchronous active-low reset (clears pointers,
//                     count and storage)
//     push_i/data_i : write one entry at the tail
//     pop_i         : drop the head entry
//     head_o        : oldest entry (meaningful while count_o != 0)
//     count_o       : number of stored entries, 0..DEPTH_P
//   Pointers wrap explicitly at DEPTH_P, so any depth >= 1 works.
//   Push and pop in the same cycle leave the count unchanged and advance both
//   pointers. The owner guarantees no push when full and no pop when empty.
// -----------------------------------------------------------------------------
module lsu_fifo #(
  parameter  int DEPTH_P = 2,
  parameter  int WIDTH_P = 8,
  localparam int PTR_W   = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1,
  localparam int CNT_W   = $clog2(DEPTH_P + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic [WIDTH_P-1:0] data_i,
  input  logic               pop_i,
  output logic [WIDTH_P-1:0] head_o,
  output logic [CNT_W-1:0]   count_o
);

  logic [WIDTH_P-1:0] mem_q [DEPTH_P];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH_P - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH_P; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/lsu_pipe.sv
// -----------------------------------------------------------------------------
// lsu_pipe
//   Load/store unit between EXE and the data-memory port. An issue register
//   holds one request until memory takes it; an in-order FIFO (lsu_fifo)
//   remembers what each outstanding access was so responses can be routed:
//   load data goes to writeback, store acknowledgements are absorbed.
//
//   Ports:
//     clk, reset        : clock, synchronous active-low reset
//     req_*_i/req_ready_o : request from EXE; transfers when valid && ready
//     mem               : lsu_pipe_if.master, data-memory request/response
//     wb_valid_o/wb_tag_o/wb_data_o/wb_ready_i : load result to writeback;
//                         a load response is consumed only when wb_ready_i
//     busy_o            : a request is in the issue register or outstanding
//     proto_err_o       : sticky; response seen with nothing outstanding
//     align_err_o       : one-cycle pulse after a misaligned word request was
//                         accepted (LSU_ALIGN_CHECK_EN builds only, else 0)
//
//   Build option: define LSU_ALIGN_CHECK_EN to drop misaligned word requests
//   instead of issuing them.
//
//   Capacity: DEPTH_P counts the issue register plus the FIFO entries, so
//   req_ready_o requires cnt + pend < DEPTH_P. The issue register may be
//   refilled in the same cycle memory takes its current contents.
// -----------------------------------------------------------------------------
module lsu_pipe
  import lsu_pipe_pkg::*;
#(
  parameter int ADDR_WIDTH_P = LSU_ADDR_W,
  parameter int DATA_WIDTH_P = LSU_DATA_W,
  parameter int TAG_WIDTH_P  = LSU_TAG_W,
  parameter int DEPTH_P      = LSU_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    req_valid_i,
  input  logic                    req_is_store_i,
  input  logic                    req_byte_i,
  input  logic [ADDR_WIDTH_P-1:0] req_addr_i,
  input  logic [DATA_WIDTH_P-1:0] req_wdata_i,
  input  logic [TAG_WIDTH_P-1:0]  req_tag_i,
  output logic                    req_ready_o,

  lsu_pipe_if.master              mem,

  output logic                    wb_valid_o,
  output logic [TAG_WIDTH_P-1:0]  wb_tag_o,
  output logic [DATA_WIDTH_P-1:0] wb_data_o,
  input  logic                    wb_ready_i,

  output logic                    busy_o,
  output logic                    proto_err_o,
  output logic                    align_err_o
);

  localparam int CNT_W = $clog2(DEPTH_P + 1);

  lsu_req_s          req_q, req_d;
  logic              pend_q, pend_d;
  logic              proto_err_q, proto_err_d;

  logic [CNT_W-1:0]  cnt;
  lsu_entry_s        head;
  lsu_entry_s        push_entry;

  logic              misaligned;
  logic [31:0]       in_flight;
  logic              accept;
  logic              issue;
  logic              push;
  logic              pop;
  logic              resp_live;

  always_comb begin
    misaligned = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    misaligned = lsu_misaligned(req_byte_i, req_addr_i[1:0]);
`endif

    in_flight   = 32'(cnt) + 32'(pend_q);
    // The issue slot is free if empty or being drained this cycle.
    req_ready_o = reset && (!pend_q || mem.mem_accept_i) &&
                  (in_flight < 32'(DEPTH_P));
    accept      = req_valid_i && req_ready_o;
    // A misaligned word request is consumed but never reaches memory.
    issue       = accept && !misaligned;

    push        = reset && pend_q && mem.mem_accept_i;
    // Only entries pushed on an earlier edge can be answered: cnt is the
    // registered count, so a same-cycle push does not make cnt non-zero.
    resp_live   = reset && mem.mem_resp_valid_i && (cnt != '0);
    pop         = resp_live && (head.is_store || wb_ready_i);

    pend_d = pend_q;
    if (push) begin
      pend_d = 1'b0;
    end
    if (issue) begin
      pend_d = 1'b1;
    end

    req_d = req_q;
    if (issue) begin
      req_d.is_store = req_is_store_i;
      req_d.byte_op  = req_byte_i;
      req_d.addr     = req_addr_i;
      req_d.wdata    = req_wdata_i;
      req_d.tag      = req_tag_i;
    end

    proto_err_d = proto_err_q ||
                  (reset && mem.mem_resp_valid_i && (cnt == '0));

    push_entry.is_store = req_q.is_store;
    push_entry.byte_op  = req_q.byte_op;
    push_entry.tag      = req_q.tag;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      req_q       <= '0;
      pend_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      req_q       <= req_d;
      pend_q      <= pend_d;
      proto_err_q <= proto_err_d;
    end
  end

  lsu_fifo #(
    .DEPTH_P (DEPTH_P),
    .WIDTH_P (LSU_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (cnt)
  );

  // Memory request side: the issue register drives the bus directly.
  assign mem.mem_valid_o = pend_q;
  assign mem.mem_addr_o  = req_q.addr;
  assign mem.mem_wdata_o = req_q.wdata;
  assign mem.mem_wen_o   = req_q.is_store;
  assign mem.mem_byte_o  = req_q.byte_op;
  assign mem.mem_yumi_o  = pop;

  // Writeback: only load responses are visible; data/tag are zero otherwise.
  assign wb_valid_o = resp_live && !head.is_store;
  assign wb_tag_o   = wb_valid_o ? head.tag : '0;
  assign wb_data_o  = wb_valid_o ? lsu_load_data(head.byte_op, mem.mem_rdata_i)
                                 : '0;

  assign busy_o      = reset && (pend_q || (cnt != '0));
  assign proto_err_o = proto_err_q;

`ifdef LSU_ALIGN_CHECK_EN
  logic align_err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      align_err_q <= 1'b0;
    end else begin
      align_err_q <= accept && misaligned;
    end
  end

  assign align_err_o = align_err_q;
`else
  assign align_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_pipe.sv
`timescale 1ns/1ps
module tb_lsu_pipe;
  import lsu_pipe_pkg::*;

  localparam int DEPTH = 2;
  localparam int RW    = 71; // {is_store, byte, tag[4:0], addr[31:0], wdata[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid_i, req_is_store_i, req_byte_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [4:0]  req_tag_i;
  logic        req_ready_o;
  logic        wb_valid_o;
  logic [4:0]  wb_tag_o;
  logic [31:0] wb_data_o;
  logic        wb_ready_i;
  logic        busy_o, proto_err_o, align_err_o;

  lsu_pipe_if mif();

  lsu_pipe #(.DEPTH_P(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid_i    (req_valid_i),
    .req_is_store_i (req_is_store_i),
    .req_byte_i     (req_byte_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_tag_i      (req_tag_i),
    .req_ready_o    (req_ready_o),
    .mem            (mif),
    .wb_valid_o     (wb_valid_o),
    .wb_tag_o       (wb_tag_o),
    .wb_data_o      (wb_data_o),
    .wb_ready_i     (wb_ready_i),
    .busy_o         (busy_o),
    .proto_err_o    (proto_err_o),
    .align_err_o    (align_err_o)
  );

  int total = 0;
  int bad   = 0;

  // scoreboard: requests accepted by the LSU, not yet taken by memory
  logic [RW-1:0] exp_q[$];
  // requests taken by memory, awaiting a response: {is_store, byte, tag}
  logic [6:0]    out_q[$];

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle;
    req_valid_i          = 1'b0;
    req_is_store_i       = 1'b0;
    req_byte_i           = 1'b0;
    req_addr_i           = '0;
    req_wdata_i          = '0;
    req_tag_i            = '0;
    mif.mem_accept_i     = 1'b0;
    mif.mem_resp_valid_i = 1'b0;
    mif.mem_rdata_i      = '0;
    wb_ready_i           = 1'b1;
  endtask

  task automatic do_reset;
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic drive_req(input logic st, input logic by, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] tag);
    req_valid_i    = 1'b1;
    req_is_store_i = st;
    req_byte_i     = by;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    req_tag_i      = tag;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    idle();
    reset = 1'b0;
    mif.mem_resp_valid_i = 1'b1;
    tick();
    settle();
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", req_ready_o); end
    total++; if (mif.mem_valid_o !== 1'b0) begin bad++; $display("FAIL rst_mem_valid: got %b want 0", mif.mem_valid_o); end
    total++; if (mif.mem_yumi_o !== 1'b0) begin bad++; $display("FAIL rst_yumi: got %b want 0", mif.mem_yumi_o); end
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    tick();
    settle();
    total++; if (proto_err_o !== 1'b0) begin bad++; $display("FAIL rst_proto: got %b want 0", proto_err_o); end
    total++; if (align_err_o !== 1'b0) begin bad++; $display("FAIL rst_align: got %b want 0", align_err_o); end
    mif.mem_resp_valid_i = 1'b0;
    reset = 1'b1;
    settle();
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready_after: got %b want 1", req_ready_o); end
    tick();
  endtask

  task automatic test_single_load;
    do_reset();
    drive_req(1'b0, 1'b0, 32'h10, 32'h0, 5'd3);
    settle();
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", req_ready_o); end
    tick();
    req_valid_i = 1'b0;
    mif.mem_accept_i = 1'b1;
    settle();
    total++; if (mif.mem_valid_o !== 1'b1) begin bad++; $display("FAIL single_mem_valid: got %b want 1", mif.mem_valid_o); end
    total++; if (mif.mem_addr_o !== 32'h10) begin bad++; $display("FAIL single_mem_addr: got %h want 00000010", mif.mem_addr_o); end
    total++; if (mif.mem_wen_o !== 1'b0) begin bad++; $display("FAIL single_mem_wen: got %b want 0", mif.mem_wen_o); end
    tick();
    mif.mem_accept_i = 1'b0;
    settle();
    total++; if (mif.mem_valid_o !== 1'b0) begin bad++; $display("FAIL single_mem_valid_low: got %b want 0", mif.mem_valid_o); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy_o); end
    tick();
    mif.mem_resp_valid_i = 1'b1;
    mif.mem_rdata_i      = 32'hDEADBEEF;
    wb_ready_i           = 1'b1;
    settle();
    total++; if (wb_valid_o !== 1'b1) begin bad++; $display("FAIL single_wb_valid: got %b want 1", wb_valid_o); end
    total++; if (wb_tag_o !== 5'd3) begin bad++; $display("FAIL single_wb_tag: got %0d want 3", wb_tag_o); end
    total++; if (wb_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wb_data: got %h want deadbeef", wb_data_o); end
    total++; if (mif.mem_yumi_o !== 1'b1) begin bad++; $display("FAIL single_yumi: got %b want 1", mif.mem_yumi_o); end
    tick();
    mif.mem_resp_valid_i = 1'b0;
    settle();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", busy_o); end
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL single_wb_valid_end: got %b want 0", wb_valid_o); end
  endtask

  task automatic test_depth_limit;
    do_reset();
    drive_req(1'b0, 1'b0, 32'h100, 32'h0, 5'd1);
    tick();
    drive_req(1'b0, 1'b0, 32'h104, 32'h0, 5'd2);
    mif.mem_accept_i = 1'b1;
    settle();
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL depth_second_ready: got %b want 1", req_ready_o); end
    tick();
    mif.mem_accept_i = 1'b0;
    drive_req(1'b0, 1'b0, 32'h108, 32'h0, 5'd4);
    settle();
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL depth_third_ready: got %b want 0", req_ready_o); end
    total++; if (mif.mem_valid_o !== 1'b1) begin bad++; $display("FAIL depth_pending: got %b want 1", mif.mem_valid_o); end
    mif.mem_accept_i = 1'b1;
    settle();
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL depth_full_with_accept: got %b want 0", req_ready_o); end
    mif.mem_accept_i = 1'b0;
    tick();
    mif.mem_resp_valid_i = 1'b1;
    mif.mem_rdata_i      = 32'h11;
    settle();
    total++; if (mif.mem_yumi_o !== 1'b1) begin bad++; $display("FAIL depth_resp_yumi: got %b want 1", mif.mem_yumi_o); end
    total++; if (wb_tag_o !== 5'd1) begin bad++; $display("FAIL depth_resp_tag: got %0d want 1", wb_tag_o); end
    tick();
    mif.mem_resp_valid_i = 1'b0;
    mif.mem_accept_i     = 1'b1;
    settle();
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL depth_ready_again: got %b want 1", req_ready_o); end
    tick();
    idle();
  endtask

  task automatic test_byte_and_store;
    do_reset();
    drive_req(1'b0, 1'b1, 32'h21, 32'h0, 5'd7);
    tick();
    req_valid_i = 1'b0;
    mif.mem_accept_i = 1'b1;
    settle();
    total++; if (mif.mem_byte_o !== 1'b1) begin bad++; $display("FAIL byte_mem_byte: got %b want 1", mif.mem_byte_o); end
    tick();
    mif.mem_accept_i     = 1'b0;
    mif.mem_resp_valid_i = 1'b1;
    mif.mem_rdata_i      = 32'h123456A7;
    settle();
    total++; if (wb_data_o !== 32'h000000A7) begin bad++; $display("FAIL byte_wb_data: got %h want 000000a7", wb_data_o); end
    total++; if (wb_tag_o !== 5'd7) begin bad++; $display("FAIL byte_wb_tag: got %0d want 7", wb_tag_o); end
    tick();
    mif.mem_resp_valid_i = 1'b0;
    drive_req(1'b1, 1'b0, 32'h40, 32'hCAFEF00D, 5'd0);
    tick();
    req_valid_i = 1'b0;
    mif.mem_accept_i = 1'b1;
    settle();
    total++; if (mif.mem_wen_o !== 1'b1) begin bad++; $display("FAIL store_wen: got %b want 1", mif.mem_wen_o); end
    total++; if (mif.mem_wdata_o !== 32'hCAFEF00D) begin bad++; $display("FAIL store_wdata: got %h want cafef00d", mif.mem_wdata_o); end
    tick();
    mif.mem_accept_i     = 1'b0;
    mif.mem_resp_valid_i = 1'b1;
    mif.mem_rdata_i      = 32'h0;
    wb_ready_i           = 1'b0;
    settle();
    total++; if (mif.mem_yumi_o !== 1'b1) begin bad++; $display("FAIL store_yumi: got %b want 1", mif.mem_yumi_o); end
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL store_wb_valid: got %b want 0", wb_valid_o); end
    tick();
    mif.mem_resp_valid_i = 1'b0;
    wb_ready_i = 1'b1;
    settle();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL store_busy_end: got %b want 0", busy_o); end
  endtask

  task automatic test_wb_stall;
    do_reset();
    drive_req(1'b0, 1'b0, 32'h30, 32'h0, 5'd9);
    tick();
    req_valid_i = 1'b0;
    mif.mem_accept_i = 1'b1;
    tick();
    mif.mem_accept_i     = 1'b0;
    mif.mem_resp_valid_i = 1'b1;
    mif.mem_rdata_i      = 32'h55AA1234;
    wb_ready_i           = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      total++; if (mif.mem_yumi_o !== 1'b0) begin bad++; $display("FAIL stall_yumi_%0d: got %b want 0", i, mif.mem_yumi_o); end
      total++; if (wb_valid_o !== 1'b1) begin bad++; $display("FAIL stall_wb_valid_%0d: got %b want 1", i, wb_valid_o); end
      total++; if (wb_data_o !== 32'h55AA1234) begin bad++; $display("FAIL stall_wb_data_%0d: got %h want 55aa1234", i, wb_data_o); end
      tick();
    end
    wb_ready_i = 1'b1;
    settle();
    total++; if (mif.mem_yumi_o !== 1'b1) begin bad++; $display("FAIL stall_release_yumi: got %b want 1", mif.mem_yumi_o); end
    total++; if (wb_tag_o !== 5'd9) begin bad++; $display("FAIL stall_release_tag: got %0d want 9", wb_tag_o); end
    tick();
    mif.mem_resp_valid_i = 1'b0;
    settle();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL stall_busy_end: got %b want 0", busy_o); end
  endtask

  task automatic test_proto_err;
    do_reset();
    mif.mem_resp_valid_i = 1'b1;
    mif.mem_rdata_i      = 32'h77;
    settle();
    total++; if (mif.mem_yumi_o !== 1'b0) begin bad++; $display("FAIL proto_yumi: got %b want 0", mif.mem_yumi_o); end
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL proto_wb_valid: got %b want 0", wb_valid_o); end
    tick();
    mif.mem_resp_valid_i = 1'b0;
    settle();
    total++; if (proto_err_o !== 1'b1) begin bad++; $display("FAIL proto_set: got %b want 1", proto_err_o); end
    tick();
    tick();
    settle();
    total++; if (proto_err_o !== 1'b1) begin bad++; $display("FAIL proto_sticky: got %b want 1", proto_err_o); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    settle();
    total++; if (proto_err_o !== 1'b0) begin bad++; $display("FAIL proto_cleared: got %b want 0", proto_err_o); end
  endtask

  task automatic test_same_cycle_resp;
    do_reset();
    drive_req(1'b0, 1'b0, 32'h50, 32'h0, 5'd12);
    tick();
    req_valid_i          = 1'b0;
    mif.mem_accept_i     = 1'b1;
    mif.mem_resp_valid_i = 1'b1;
    settle();
    total++; if (mif.mem_yumi_o !== 1'b0) begin bad++; $display("FAIL same_cycle_yumi: got %b want 0", mif.mem_yumi_o); end
    tick();
    mif.mem_accept_i     = 1'b0;
    mif.mem_resp_valid_i = 1'b0;
    settle();
    total++; if (proto_err_o !== 1'b1) begin bad++; $display("FAIL same_cycle_proto: got %b want 1", proto_err_o); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL same_cycle_busy: got %b want 1", busy_o); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    drive_req(1'b0, 1'b0, 32'h60, 32'h0, 5'd5);
    tick();
    req_valid_i = 1'b0;
    settle();
    total++; if (mif.mem_valid_o !== 1'b1) begin bad++; $display("FAIL mid_pending: got %b want 1", mif.mem_valid_o); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    settle();
    total++; if (mif.mem_valid_o !== 1'b0) begin bad++; $display("FAIL mid_mem_valid: got %b want 0", mif.mem_valid_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy_o); end
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", req_ready_o); end
  endtask

  task automatic test_align;
    do_reset();
    drive_req(1'b1, 1'b0, 32'h6, 32'hA5A5A5A5, 5'd0);
    settle();
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL align_ready: got %b want 1", req_ready_o); end
    tick();
    req_valid_i = 1'b0;
    settle();
`ifdef LSU_ALIGN_CHECK_EN
    total++; if (align_err_o !== 1'b1) begin bad++; $display("FAIL align_pulse: got %b want 1", align_err_o); end
    total++; if (mif.mem_valid_o !== 1'b0) begin bad++; $display("FAIL align_not_issued: got %b want 0", mif.mem_valid_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL align_busy: got %b want 0", busy_o); end
    tick();
    settle();
    total++; if (align_err_o !== 1'b0) begin bad++; $display("FAIL align_pulse_end: got %b want 0", align_err_o); end
    drive_req(1'b1, 1'b1, 32'h6, 32'h5A, 5'd0);
    tick();
    req_valid_i = 1'b0;
    settle();
`endif
    total++; if (mif.mem_valid_o !== 1'b1) begin bad++; $display("FAIL align_issued: got %b want 1", mif.mem_valid_o); end
    total++; if (mif.mem_addr_o !== 32'h6) begin bad++; $display("FAIL align_addr: got %h want 00000006", mif.mem_addr_o); end
    total++; if (align_err_o !== 1'b0) begin bad++; $display("FAIL align_no_err: got %b want 0", align_err_o); end
  endtask

  // Random traffic against an in-order memory model and request scoreboard.
  task automatic test_random;
    logic          req_pending;
    logic          resp_active;
    logic          exp_ready;
    logic          exp_yumi;
    logic [6:0]    head;
    logic [31:0]   exp_data;
    logic [RW-1:0] e;
    logic [31:0]   a;
    logic          by;
    int            cyc;
    do_reset();
    exp_q.delete();
    out_q.delete();
    req_pending = 1'b0;
    resp_active = 1'b0;
    cyc = 0;
    while (cyc < 1500 || req_pending || exp_q.size() != 0 || out_q.size() != 0) begin
      if (cyc >= 4000) begin
        total++; bad++;
        $display("FAIL random_timeout: got %0d in flight want 0", exp_q.size() + out_q.size());
        break;
      end
      if (!req_pending && cyc < 1500 && $urandom_range(0, 1) == 1) begin
        by = 1'($urandom_range(0, 1));
        a  = $urandom;
        if (!by) a[1:0] = 2'b00;
        drive_req(1'($urandom_range(0, 1)), by, a, $urandom, 5'($urandom_range(0, 31)));
        req_pending = 1'b1;
      end
      req_valid_i = req_pending;
      mif.mem_accept_i = ($urandom_range(0, 2) != 0);
      if (!resp_active && out_q.size() != 0 && $urandom_range(0, 2) == 0) begin
        resp_active = 1'b1;
        mif.mem_rdata_i = $urandom;
      end
      mif.mem_resp_valid_i = resp_active;
      wb_ready_i = ($urandom_range(0, 3) != 0);
      settle();

      exp_ready = ((exp_q.size() == 0) || mif.mem_accept_i) && ((exp_q.size() + out_q.size()) < DEPTH);
      total++; if (req_ready_o !== exp_ready) begin bad++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, req_ready_o, exp_ready); end
      total++; if (mif.mem_valid_o !== (exp_q.size() != 0)) begin bad++; $display("FAIL rnd_mem_valid c%0d: got %b want %b", cyc, mif.mem_valid_o, exp_q.size() != 0); end
      total++; if (busy_o !== ((exp_q.size() + out_q.size()) != 0)) begin bad++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, busy_o, (exp_q.size() + out_q.size()) != 0); end
      total++; if (proto_err_o !== 1'b0) begin bad++; $display("FAIL rnd_proto c%0d: got %b want 0", cyc, proto_err_o); end

      exp_yumi = 1'b0;
      if (resp_active) begin
        head = out_q[0];
        exp_yumi = head[6] || wb_ready_i;
        if (head[6]) begin
          total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL rnd_store_wb c%0d: got %b want 0", cyc, wb_valid_o); end
        end else begin
          exp_data = head[5] ? {24'h0, mif.mem_rdata_i[7:0]} : mif.mem_rdata_i;
          total++; if (wb_valid_o !== 1'b1) begin bad++; $display("FAIL rnd_load_wb c%0d: got %b want 1", cyc, wb_valid_o); end
          total++; if (wb_tag_o !== head[4:0]) begin bad++; $display("FAIL rnd_tag c%0d: got %0d want %0d", cyc, wb_tag_o, head[4:0]); end
          total++; if (wb_data_o !== exp_data) begin bad++; $display("FAIL rnd_data c%0d: got %h want %h", cyc, wb_data_o, exp_data); end
        end
      end else begin
        total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL rnd_idle_wb c%0d: got %b want 0", cyc, wb_valid_o); end
      end
      total++; if (mif.mem_yumi_o !== exp_yumi) begin bad++; $display("FAIL rnd_yumi c%0d: got %b want %b", cyc, mif.mem_yumi_o, exp_yumi); end

      if (mif.mem_valid_o && mif.mem_accept_i && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        if ({mif.mem_wen_o, mif.mem_byte_o, mif.mem_addr_o, mif.mem_wdata_o} !== {e[70:69], e[63:0]}) begin
          bad++;
          $display("FAIL rnd_mem_req c%0d: got %b %b %h %h want %b %b %h %h", cyc,
                   mif.mem_wen_o, mif.mem_byte_o, mif.mem_addr_o, mif.mem_wdata_o,
                   e[70], e[69], e[63:32], e[31:0]);
        end
        out_q.push_back(e[70:64]);
      end
      if (req_valid_i && req_ready_o) begin
        exp_q.push_back({req_is_store_i, req_byte_i, req_tag_i, req_addr_i, req_wdata_i});
        req_pending = 1'b0;
      end
      if (exp_yumi) begin
        void'(out_q.pop_front());
        resp_active = 1'b0;
      end
      tick();
      cyc++;
    end
    idle();
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    idle();
    test_reset();
    test_single_load();
    test_depth_limit();
    test_byte_and_store();
    test_wb_stall();
    test_proto_err();
    test_same_cycle_resp();
    test_reset_mid();
    test_align();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
